// File: rtl/axis_sample_player.sv
// Reassembles 8-bit AXI-Stream bytes into 64-bit {ch4,ch3,ch2,ch1} samples, buffers them
// in a small FIFO and releases one sample every rate_div clocks to the DAC driver.
//
// state  | meaning
// S_IDLE | waiting for play_start; stream not accepted
// S_PLAY | accepting bytes, pacing samples out until play_len popped or aborted
module axis_sample_player #(
  parameter int BUF_DEPTH = 4,
  parameter int UCNT_W    = 16
) (
  input  logic              dac_clk,
  input  logic              dac_rst,
  input  logic [31:0]       play_len,
  input  logic              play_start,
  input  logic              play_abort,
  input  logic [15:0]       rate_div,
  output logic              busy,
  output logic              done,
  output logic              frame_err,
  output logic [UCNT_W-1:0] underrun_cnt,
  input  logic [7:0]        S_AXIS_tdata,
  input  logic              S_AXIS_tkeep,
  input  logic              S_AXIS_tlast,
  input  logic              S_AXIS_tvalid,
  output logic              S_AXIS_tready,
  output logic              sample_valid,
  output logic [63:0]       sample_data
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {S_IDLE, S_PLAY} state_t;

  state_t              state_q, state_d;
  logic [31:0]         len_q, len_d;
  logic [15:0]         rdiv_q, rdiv_d;
  logic [15:0]         rate_cnt_q, rate_cnt_d;
  logic [31:0]         in_cnt_q, in_cnt_d;
  logic [31:0]         out_cnt_q, out_cnt_d;
  logic [2:0]          byte_cnt_q, byte_cnt_d;
  logic [6:0][7:0]     bytes_q, bytes_d;
  logic [63:0]         mem_q [BUF_DEPTH];
  logic [63:0]         mem_d [BUF_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                frame_err_q, frame_err_d;
  logic [UCNT_W-1:0]   ucnt_q, ucnt_d;
  logic                done_q, done_d;
  logic                last_pop_q, last_pop_d;
  logic                sample_valid_q, sample_valid_d;
  logic [63:0]         sample_data_q, sample_data_d;

  logic        fifo_full, tready, hs, tick, push, pop, exp_last;
  logic [15:0] rdiv_eff;
  logic        unused_tkeep;

  assign unused_tkeep = S_AXIS_tkeep;
  assign rdiv_eff  = (rate_div == 16'd0) ? 16'd1 : rate_div;
  assign fifo_full = (count_q == CW'(BUF_DEPTH));
  assign tready    = (state_q == S_PLAY) && !fifo_full && (in_cnt_q != len_q);
  assign hs        = S_AXIS_tvalid && tready;
  assign tick      = (state_q == S_PLAY) && (rate_cnt_q == 16'd0);
  assign exp_last  = (byte_cnt_q == 3'd7) && (in_cnt_q == len_q - 32'd1);

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    rdiv_d         = rdiv_q;
    rate_cnt_d     = rate_cnt_q;
    in_cnt_d       = in_cnt_q;
    out_cnt_d      = out_cnt_q;
    byte_cnt_d     = byte_cnt_q;
    bytes_d        = bytes_q;
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    frame_err_d    = frame_err_q;
    ucnt_d         = ucnt_q;
    done_d         = last_pop_q;
    last_pop_d     = 1'b0;
    sample_valid_d = 1'b0;
    sample_data_d  = sample_data_q;
    push           = 1'b0;
    pop            = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (play_start) begin
          if (play_len != 32'd0) begin
            state_d     = S_PLAY;
            len_d       = play_len;
            rdiv_d      = rdiv_eff;
            rate_cnt_d  = rdiv_eff - 16'd1;
            in_cnt_d    = 32'd0;
            out_cnt_d   = 32'd0;
            byte_cnt_d  = 3'd0;
            frame_err_d = 1'b0;
            ucnt_d      = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (play_abort) begin
          state_d    = S_IDLE;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          byte_cnt_d = 3'd0;
        end else begin
          if (hs) begin
            byte_cnt_d = byte_cnt_q + 3'd1;
            if (S_AXIS_tlast != exp_last) frame_err_d = 1'b1;
            if (byte_cnt_q != 3'd7) begin
              bytes_d[byte_cnt_q] = S_AXIS_tdata;
            end else begin
              push            = 1'b1;
              mem_d[wr_ptr_q] = {S_AXIS_tdata, bytes_q};
              wr_ptr_d        = wr_ptr_q + PW'(1);
              in_cnt_d        = in_cnt_q + 32'd1;
            end
          end
          // Only words present before this edge can pop; a same-edge push waits a tick.
          if (tick) begin
            rate_cnt_d = rdiv_q - 16'd1;
            if (count_q != '0) begin
              pop            = 1'b1;
              sample_valid_d = 1'b1;
              sample_data_d  = mem_q[rd_ptr_q];
              rd_ptr_d       = rd_ptr_q + PW'(1);
              out_cnt_d      = out_cnt_q + 32'd1;
              if (out_cnt_q == len_q - 32'd1) begin
                state_d    = S_IDLE;
                last_pop_d = 1'b1;
              end
            end else if (ucnt_q != {UCNT_W{1'b1}}) begin
              ucnt_d = ucnt_q + UCNT_W'(1);
            end
          end else begin
            rate_cnt_d = rate_cnt_q - 16'd1;
          end
          if (push && !pop)      count_d = count_q + CW'(1);
          else if (pop && !push) count_d = count_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      rdiv_q         <= '0;
      rate_cnt_q     <= '0;
      in_cnt_q       <= '0;
      out_cnt_q      <= '0;
      byte_cnt_q     <= '0;
      bytes_q        <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      frame_err_q    <= 1'b0;
      ucnt_q         <= '0;
      done_q         <= 1'b0;
      last_pop_q     <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      rdiv_q         <= rdiv_d;
      rate_cnt_q     <= rate_cnt_d;
      in_cnt_q       <= in_cnt_d;
      out_cnt_q      <= out_cnt_d;
      byte_cnt_q     <= byte_cnt_d;
      bytes_q        <= bytes_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      frame_err_q    <= frame_err_d;
      ucnt_q         <= ucnt_d;
      done_q         <= done_d;
      last_pop_q     <= last_pop_d;
      sample_valid_q <= sample_valid_d;
      sample_data_q  <= sample_data_d;
    end
  end

  assign busy          = (state_q == S_PLAY);
  assign done          = done_q;
  assign frame_err     = frame_err_q;
  assign underrun_cnt  = ucnt_q;
  assign S_AXIS_tready = tready;
  assign sample_valid  = sample_valid_q;
  assign sample_data   = sample_data_q;

endmodule

// File: tb/tb_axis_sample_player.sv
// Randomized and directed playback runs checked against a queue-based sample model:
// expected words, tick-phase timing, underrun totals and framing errors.
module tb_axis_sample_player;
  localparam int BUF_DEPTH = 4;
  localparam int UCNT_W    = 16;
  localparam int BUDGET    = 5000;

  logic              dac_clk = 1'b0;
  logic              dac_rst;
  logic [31:0]       play_len;
  logic              play_start, play_abort;
  logic [15:0]       rate_div;
  logic              busy, done, frame_err;
  logic [UCNT_W-1:0] underrun_cnt;
  logic [7:0]        tdata;
  logic              tkeep, tlast, tvalid, tready;
  logic              sample_valid;
  logic [63:0]       sample_data;

  always #5 dac_clk = ~dac_clk;

  axis_sample_player #(.BUF_DEPTH(BUF_DEPTH), .UCNT_W(UCNT_W)) dut (
    .dac_clk(dac_clk), .dac_rst(dac_rst), .play_len(play_len), .play_start(play_start),
    .play_abort(play_abort), .rate_div(rate_div), .busy(busy), .done(done),
    .frame_err(frame_err), .underrun_cnt(underrun_cnt), .S_AXIS_tdata(tdata),
    .S_AXIS_tkeep(tkeep), .S_AXIS_tlast(tlast), .S_AXIS_tvalid(tvalid),
    .S_AXIS_tready(tready), .sample_valid(sample_valid), .sample_data(sample_data));

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] last_data;
  logic [63:0] got[$];
  int          last_k;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One run: bench feeds 8*len bytes (one offer every 'gap' cycles), model predicts
  // sample order, strobe phase, done timing, underruns and frame_err.
  task automatic run(input int len, input int rdiv, input int gap, input int bad_idx,
                     input int abort_at, input bit seq_data, input bit fill_chk);
    logic [7:0]  bq[$];
    bit          tl[$];
    logic [63:0] exp_q[$];
    logic [63:0] w;
    int n, reff, idx, seen, k_last, abort_k, fill_exp;
    bit err_exp, hs_prev, aborted, finished;
    n = 8 * len;
    reff = (rdiv == 0) ? 1 : rdiv;
    err_exp = 1'b0;
    for (int i = 0; i < n; i++) begin
      bq.push_back(seq_data ? 8'(i + 1) : 8'($urandom));
      tl.push_back((bad_idx >= 0) ? (i == bad_idx) : (i == n - 1));
      if (tl[i] != (i == n - 1)) err_exp = 1'b1;
    end
    for (int j = 0; j < len; j++) begin
      for (int b = 0; b < 8; b++) w[8*b +: 8] = bq[8*j + b];
      exp_q.push_back(w);
    end
    fill_exp = (n < 8 * BUF_DEPTH) ? n : 8 * BUF_DEPTH;
    got.delete();

    @(negedge dac_clk);
    play_len = len; rate_div = 16'(rdiv); play_start = 1'b1;
    @(negedge dac_clk);
    play_start = 1'b0;
    chk("start_frame_err_clear", frame_err, 0);
    chk("start_underrun_clear", underrun_cnt, 0);

    idx = 0; seen = 0; k_last = -1; abort_k = -1;
    hs_prev = 0; aborted = 0; finished = 0;
    for (int k = 0; k < BUDGET; k++) begin
      if (k > 0) @(negedge dac_clk);
      if (hs_prev) begin idx++; tvalid = 1'b0; end
      if (sample_valid) begin
        if (exp_q.size() == 0) chk("extra_strobe", 1, 0);
        else chk("sample_data", sample_data, exp_q.pop_front());
        chk("strobe_phase", (k > 0) && (k % reff == 0), 1);
        last_data = sample_data;
        got.push_back(sample_data);
        seen++;
        if (seen == len) k_last = k;
      end else begin
        chk("data_hold", sample_data, last_data);
      end
      chk("busy", busy, aborted ? 0 : (seen < len));
      chk("done", done, !aborted && k_last >= 0 && k == k_last + 1);
      if (!busy) chk("tready_idle", tready, 0);
      if (fill_chk && k == reff - 1) begin
        chk("fill_bytes", idx, fill_exp);
        chk("fill_tready", tready, 0);
      end
      if (!aborted && k_last >= 0 && k == k_last + 1) begin
        chk("underrun_total", underrun_cnt, k_last / reff - len);
        chk("frame_err", frame_err, err_exp);
        chk("bytes_accepted", idx, n);
        last_k = k_last;
        finished = 1;
        break;
      end
      if (aborted && k >= abort_k + 8) begin finished = 1; break; end
      if (!aborted && abort_at >= 0 && idx == abort_at) begin
        tvalid = 1'b0; play_abort = 1'b1; aborted = 1; abort_k = k;
      end else begin
        play_abort = 1'b0;
        if (aborted && k == abort_k + 1) chk("abort_tready", tready, 0);
        if (!tvalid && !aborted && idx < n && (k % gap == 0)) begin
          tvalid = 1'b1; tdata = bq[idx]; tlast = tl[idx];
        end
      end
      hs_prev = tvalid && tready;
    end
    if (!finished) chk("run_timeout", 1, 0);
    tvalid = 1'b0; tlast = 1'b0; play_abort = 1'b0;
  endtask

  initial begin
    dac_rst = 1'b1; play_len = 0; play_start = 0; play_abort = 0; rate_div = 0;
    tdata = 8'hA5; tkeep = 1'b1; tlast = 1'b0; tvalid = 1'b1;
    last_data = '0; last_k = 0;
    repeat (3) @(negedge dac_clk);
    chk("rst_tready", tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sample_data", sample_data, 0);
    chk("rst_underrun", underrun_cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    dac_rst = 1'b0; tvalid = 1'b0;
    @(negedge dac_clk);

    run(2, 4, 1, -1, -1, 1, 0);
    chk("t2_word0", got[0], 64'h0807060504030201);
    chk("t2_word1", got[1], 64'h100F0E0D0C0B0A09);
    chk("t2_underrun", underrun_cnt, 3);
    chk("t2_last_strobe_k", last_k, 20);

    run(8, 100, 1, -1, -1, 0, 1);
    chk("t3_no_underrun", underrun_cnt, 0);

    run(3, 2, 4, -1, -1, 0, 0);
    chk("t4_underrun_nonzero", underrun_cnt != 0, 1);

    run(1, 3, 1, 2, -1, 0, 0);
    repeat (3) @(negedge dac_clk);
    chk("t5_frame_err_sticky", frame_err, 1);

    run(4, 50, 1, -1, 12, 0, 0);
    run(1, 2, 1, -1, -1, 0, 0);

    @(negedge dac_clk);
    play_len = 0; play_start = 1'b1;
    @(negedge dac_clk);
    play_start = 1'b0;
    chk("zero_len_done", done, 1);
    chk("zero_len_busy", busy, 0);
    @(negedge dac_clk);
    chk("zero_len_done_pulse", done, 0);

    for (int r = 0; r < 6; r++)
      run($urandom_range(1, 5), $urandom_range(0, 6), $urandom_range(1, 3), -1, -1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
